// File: rtl/canvas_pkg.sv
// canvas_pkg: definitions shared by the pixel store and the brush painter.
//   - canvas geometry (MAX_COORDINATE square canvas, coordinate/address widths)
//   - 3-bit colour codes, ERASE being the background colour
//   - painter FSM state encoding
//   - pixel_addr(): packs a canvas coordinate into a RAM write address
package canvas_pkg;

   localparam int MAX_COORDINATE = 128;
   localparam int MAX_RADIUS     = 7;
   localparam int COORD_W        = 8;
   localparam int ROW_W          = 7;                    // y bits kept in the address
   localparam int ADDR_W         = ROW_W + COORD_W;      // {y[6:0], x[7:0]}
   localparam int RADIUS_W       = $clog2(MAX_RADIUS + 1);
   localparam int COLOR_W        = 3;

   // Highest legal coordinate, widened to the 9-bit box arithmetic.
   localparam logic [8:0] COORD_LAST = 9'(MAX_COORDINATE - 1);

   typedef enum logic [COLOR_W-1:0] {
      ERASE  = 3'b000,
      RED    = 3'b100,
      GREEN  = 3'b010,
      BLUE   = 3'b001,
      YELLOW = 3'b110,
      PURPLE = 3'b101
   } color_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      STAMP = 3'd2,
      CLEAR = 3'd3,
      DONE  = 3'd4
   } painter_state_t;

   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ROW_W-1:0]   y,
                                                    input logic [COORD_W-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/brush_painter_raster_sweep.sv
// raster_sweep: loadable 2-D counter walking a rectangular box in raster order.
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture x_start/x_end/y_start/y_end; position goes to (x_start, y_start)
//   step            : advance one pixel (x first, then wrap x and advance y)
//   x, y            : current position
//   last            : current position is the bottom-right corner of the box
// The counter does not wrap past the last pixel by itself; the owner stops
// stepping once last is seen.
module raster_sweep #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [X_W-1:0] x_start,
   input  logic [X_W-1:0] x_end,
   input  logic [Y_W-1:0] y_start,
   input  logic [Y_W-1:0] y_end,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   logic [X_W-1:0] x_lo;
   logic [X_W-1:0] x_hi;
   logic [Y_W-1:0] y_hi;

   assign last = (x == x_hi) && (y == y_hi);

   // Box bounds and current position.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_lo <= '0;
         x_hi <= '0;
         y_hi <= '0;
         x    <= '0;
         y    <= '0;
      end else if (load) begin
         x_lo <= x_start;
         x_hi <= x_end;
         y_hi <= y_end;
         x    <= x_start;
         y    <= y_start;
      end else if (step) begin
         if (x == x_hi) begin
            x <= x_lo;
            y <= y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end else begin
         x <= x;
         y <= y;
      end
   end

endmodule

// File: rtl/brush_painter.sv
// brush_painter: write-side engine for the pixel RAM. Accepts brush-stamp and
// canvas-clear commands and expands each into one pixel write per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   cmd_valid    : command offered
//   cmd_ready    : engine idle; command accepted on valid & ready at posedge
//   cmd_clear    : 1 = clear whole canvas, 0 = brush stamp
//   cmd_x/cmd_y  : brush centre
//   cmd_radius   : half-width of the square brush (0 = single pixel)
//   cmd_color    : stamp colour (ignored for clear)
//   wr_en        : RAM write strobe
//   wr_addr      : RAM write address {y[6:0], x[7:0]}
//   wr_data      : RAM write colour
//   busy         : command in progress
//   done         : one-cycle pulse when a command completes
module brush_painter
   import canvas_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_clear,
   input  logic [COORD_W-1:0]  cmd_x,
   input  logic [COORD_W-1:0]  cmd_y,
   input  logic [RADIUS_W-1:0] cmd_radius,
   input  logic [COLOR_W-1:0]  cmd_color,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [COLOR_W-1:0]  wr_data,
   output logic                busy,
   output logic                done
);

   painter_state_t state;
   painter_state_t next_state;

   logic [COORD_W-1:0]  lat_x;
   logic [COORD_W-1:0]  lat_y;
   logic [RADIUS_W-1:0] lat_r;
   logic [COLOR_W-1:0]  lat_color;

   // Set on the cycle the final pixel of the box is being presented, so the
   // FSM leaves STAMP/CLEAR one cycle later and done lands after that write.
   logic wr_last;

   logic accept;
   logic next_wr_en;
   logic [ADDR_W-1:0]  next_wr_addr;
   logic [COLOR_W-1:0] next_wr_data;
   logic next_wr_last;

   logic [8:0] cx9, cy9, r9, x_hi, y_hi;
   logic [8:0] box_x0, box_x1, box_y0, box_y1;
   logic       box_empty;

   logic               sweep_load;
   logic               sweep_step;
   logic               use_box;
   logic [COORD_W-1:0] sweep_x;
   logic [ROW_W-1:0]   sweep_y;
   logic               sweep_last;
   logic [COORD_W-1:0] sx_start, sx_end;
   logic [ROW_W-1:0]   sy_start, sy_end;

   assign cmd_ready = (state == IDLE) & ~reset;
   assign accept    = cmd_valid & cmd_ready;

   // Clipped bounding box of the latched brush, in 9-bit unsigned arithmetic
   // so cx+r (up to 262) cannot wrap; cx-r is clamped at 0 before it goes negative.
   always_comb begin
      cx9       = {1'b0, lat_x};
      cy9       = {1'b0, lat_y};
      r9        = {{(9-RADIUS_W){1'b0}}, lat_r};
      x_hi      = cx9 + r9;
      y_hi      = cy9 + r9;
      box_x0    = (cx9 < r9) ? 9'd0 : (cx9 - r9);
      box_y0    = (cy9 < r9) ? 9'd0 : (cy9 - r9);
      box_x1    = (x_hi > COORD_LAST) ? COORD_LAST : x_hi;
      box_y1    = (y_hi > COORD_LAST) ? COORD_LAST : y_hi;
      box_empty = (box_x0 > box_x1) | (box_y0 > box_y1);
   end

   // Sweep is loaded with the clipped box from SETUP, or the full canvas on a clear accept.
   assign use_box  = (state == SETUP);
   assign sx_start = use_box ? box_x0[COORD_W-1:0] : '0;
   assign sx_end   = use_box ? box_x1[COORD_W-1:0] : COORD_LAST[COORD_W-1:0];
   assign sy_start = use_box ? box_y0[ROW_W-1:0]   : '0;
   assign sy_end   = use_box ? box_y1[ROW_W-1:0]   : COORD_LAST[ROW_W-1:0];

   raster_sweep #(
      .X_W (COORD_W),
      .Y_W (ROW_W)
   ) u_sweep (
      .clk     (clk),
      .reset   (reset),
      .load    (sweep_load),
      .step    (sweep_step),
      .x_start (sx_start),
      .x_end   (sx_end),
      .y_start (sy_start),
      .y_end   (sy_end),
      .x       (sweep_x),
      .y       (sweep_y),
      .last    (sweep_last)
   );

   // Next-state and next write-port values.
   always_comb begin
      next_state   = state;
      sweep_load   = 1'b0;
      sweep_step   = 1'b0;
      next_wr_en   = 1'b0;
      next_wr_addr = wr_addr;
      next_wr_data = wr_data;
      next_wr_last = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cmd_clear) begin
                  next_state = CLEAR;
                  sweep_load = 1'b1;
               end else begin
                  next_state = SETUP;
               end
            end else begin
               next_state = IDLE;
            end
         end
         SETUP: begin
            if (box_empty) begin
               next_state = DONE;
            end else begin
               next_state = STAMP;
               sweep_load = 1'b1;
            end
         end
         STAMP, CLEAR: begin
            if (wr_last) begin
               next_state = DONE;
            end else begin
               next_wr_en   = 1'b1;
               next_wr_addr = pixel_addr(sweep_y, sweep_x);
               next_wr_data = (state == STAMP) ? lat_color : ERASE;
               next_wr_last = sweep_last;
               sweep_step   = ~sweep_last;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_last <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= next_state;
         wr_en   <= next_wr_en;
         wr_addr <= next_wr_addr;
         wr_data <= next_wr_data;
         wr_last <= next_wr_last;
         busy    <= (next_state != IDLE);
         done    <= (next_state == DONE);
      end
   end

   // Command fields captured at acceptance and held for the whole command.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_x     <= '0;
         lat_y     <= '0;
         lat_r     <= '0;
         lat_color <= '0;
      end else if (accept) begin
         lat_x     <= cmd_x;
         lat_y     <= cmd_y;
         lat_r     <= cmd_radius;
         lat_color <= cmd_color;
      end else begin
         lat_x     <= lat_x;
         lat_y     <= lat_y;
         lat_r     <= lat_r;
         lat_color <= lat_color;
      end
   end

endmodule
